// File: rtl/mux_8to1_pkg.sv
// rtl/mux_8to1_pkg.sv - shared constants and types for the 8:1 lane select
package mux_8to1_pkg;

   localparam int N_IN  = 8;
   localparam int SEL_W = 3;

   typedef logic [SEL_W-1:0] sel_t;

endpackage : mux_8to1_pkg

// File: rtl/mux_8to1_if.sv
// rtl/mux_8to1_if.sv - lane bus, select and registered result of the 8:1 mux
interface mux_8to1_if
   import mux_8to1_pkg::*;
#(
   parameter int DATA_W = 1
) ();

   logic [N_IN*DATA_W-1:0] i;
   sel_t                   s;
   logic                   in_valid;
   logic [DATA_W-1:0]      o;
   logic                   out_valid;

   modport master (
      output i, s, in_valid,
      input  o, out_valid
   );

   modport slave (
      input  i, s, in_valid,
      output o, out_valid
   );

endinterface : mux_8to1_if

// File: rtl/mux_8to1_core.sv
// rtl/mux_8to1_core.sv - combinational pick of one lane from the packed bus
module mux_8to1_core
   import mux_8to1_pkg::*;
#(
   parameter int DATA_W = 1
) (
   input  logic [N_IN*DATA_W-1:0] lanes_i,
   input  sel_t                   sel_i,
   output logic [DATA_W-1:0]      lane_o
);

   // Unknown selects fall to zero so simulation agrees with the synthesized netlist.
   always_comb begin
      lane_o = '0;
      case (sel_i)
         3'd0:    lane_o = lanes_i[0*DATA_W +: DATA_W];
         3'd1:    lane_o = lanes_i[1*DATA_W +: DATA_W];
         3'd2:    lane_o = lanes_i[2*DATA_W +: DATA_W];
         3'd3:    lane_o = lanes_i[3*DATA_W +: DATA_W];
         3'd4:    lane_o = lanes_i[4*DATA_W +: DATA_W];
         3'd5:    lane_o = lanes_i[5*DATA_W +: DATA_W];
         3'd6:    lane_o = lanes_i[6*DATA_W +: DATA_W];
         3'd7:    lane_o = lanes_i[7*DATA_W +: DATA_W];
         default: lane_o = '0;
      endcase
   end

endmodule : mux_8to1_core

// File: rtl/mux_8to1.sv
// rtl/mux_8to1.sv - registered 8:1 lane select with valid tracking
module mux_8to1
   import mux_8to1_pkg::sel_t;
#(
   parameter int DATA_W = 1,
   parameter int N_IN   = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   mux_8to1_if.slave  bus
);

   if (N_IN != 8) begin : g_bad_n_in
      $error("mux_8to1: N_IN must be 8");
   end

   logic [DATA_W-1:0] lane;
   logic [DATA_W-1:0] o_d, o_q;
   logic              out_valid_d, out_valid_q;

   mux_8to1_core #(.DATA_W(DATA_W)) u_core (
      .lanes_i (bus.i),
      .sel_i   (sel_t'(bus.s)),
      .lane_o  (lane)
   );

   // Output holds across idle cycles; only the valid flag drops.
   always_comb begin
      o_d         = o_q;
      out_valid_d = 1'b0;
      if (bus.in_valid) begin
         o_d         = lane;
         out_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_q         <= '0;
         out_valid_q <= 1'b0;
      end else begin
         o_q         <= o_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.o         = o_q;
   assign bus.out_valid = out_valid_q;

endmodule : mux_8to1

// File: tb/tb_mux_8to1.sv
// tb/tb_mux_8to1.sv - directed self-checking bench for mux_8to1
module tb_mux_8to1;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   mux_8to1_if #(.DATA_W(1)) bn ();
   mux_8to1_if #(.DATA_W(4)) bw ();

   mux_8to1 #(.DATA_W(1)) u_dut_n (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bn)
   );

   mux_8to1 #(.DATA_W(4)) u_dut_w (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bw)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, observed timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] sweep_exp;
   logic [7:0] data_vec [4];
   logic [3:0] data_exp;

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      bn.i = 8'hFF; bn.s = 3'd5; bn.in_valid = 1'b1;
      bw.i = 32'h7654_3210; bw.s = 3'd6; bw.in_valid = 1'b1;

      // Test 1: reset holds outputs low while clk toggles with valid input
      #2;
      check("rst_o_pre_clk", 32'(bn.o), 32'd0);
      check("rst_ov_pre_clk", 32'(bn.out_valid), 32'd0);
      for (int k = 0; k < 3; k++) begin
         step();
         check("rst_o", 32'(bn.o), 32'd0);
         check("rst_ov", 32'(bn.out_valid), 32'd0);
         check("rst_w_o", 32'(bw.o), 32'd0);
      end
      rst_n = 1'b1;
      step();
      check("rel_o", 32'(bn.o), 32'd1);
      check("rel_ov", 32'(bn.out_valid), 32'd1);

      // Test 2: full select sweep over 1010_0101
      sweep_exp = 8'b1010_0101;
      bn.i = 8'b1010_0101;
      for (int k = 0; k < 8; k++) begin
         bn.s = 3'(k);
         step();
         check("sweep_o", 32'(bn.o), 32'(sweep_exp[k]));
         check("sweep_ov", 32'(bn.out_valid), 32'd1);
      end

      // Test 3: data changes at fixed select 3
      data_vec[0] = 8'h08; data_vec[1] = 8'h00; data_vec[2] = 8'hF7; data_vec[3] = 8'hFF;
      data_exp = 4'b1001;
      bn.s = 3'd3;
      for (int k = 0; k < 4; k++) begin
         bn.i = data_vec[k];
         step();
         check("data_o", 32'(bn.o), 32'(data_exp[k]));
      end

      // Test 4: valid gating holds o, drops out_valid
      bn.i = 8'h01; bn.s = 3'd0; bn.in_valid = 1'b1;
      step();
      check("gate_load_o", 32'(bn.o), 32'd1);
      check("gate_load_ov", 32'(bn.out_valid), 32'd1);
      bn.i = 8'h00; bn.in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         check("gate_hold_o", 32'(bn.o), 32'd1);
         check("gate_hold_ov", 32'(bn.out_valid), 32'd0);
      end

      // Test 5: asynchronous reset between edges during a sweep
      bn.i = 8'b1010_0101; bn.in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         bn.s = 3'(k);
         step();
         check("mid_sweep_o", 32'(bn.o), 32'(sweep_exp[k]));
      end
      bn.s = 3'd3;
      #3;
      rst_n = 1'b0;
      #1;
      check("async_o", 32'(bn.o), 32'd0);
      check("async_ov", 32'(bn.out_valid), 32'd0);
      step();
      check("async_hold_o", 32'(bn.o), 32'd0);
      check("async_hold_ov", 32'(bn.out_valid), 32'd0);
      rst_n = 1'b1;
      bn.s = 3'd3;
      step();
      check("resume_s3_o", 32'(bn.o), 32'd0);
      check("resume_s3_ov", 32'(bn.out_valid), 32'd1);
      bn.s = 3'd5;
      step();
      check("resume_s5_o", 32'(bn.o), 32'd1);

      // Test 6: four-bit lanes
      bw.i = 32'h7654_3210; bw.in_valid = 1'b1;
      bw.s = 3'd6;
      step();
      check("wide_s6", 32'(bw.o), 32'h6);
      check("wide_ov", 32'(bw.out_valid), 32'd1);
      bw.s = 3'd0;
      step();
      check("wide_s0", 32'(bw.o), 32'h0);
      bw.s = 3'd7;
      step();
      check("wide_s7", 32'(bw.o), 32'h7);
      bw.s = 3'd3;
      step();
      check("wide_s3", 32'(bw.o), 32'h3);
      bw.in_valid = 1'b0; bw.s = 3'd5;
      step();
      check("wide_hold_o", 32'(bw.o), 32'h3);
      check("wide_hold_ov", 32'(bw.out_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_mux_8to1

// File: doc/mux_8to1.md
Name: mux_8to1

Overview:
Registered 8:1 bit-select multiplexer. It picks one of eight input lanes using a 3-bit select and drives the chosen lane onto a registered output, one clock after sampling. It sits wherever a datapath needs to pick one lane of an 8-lane bus. With default parameters it is a single-bit 8:1 mux: o equals i[s].

Parameters:
- DATA_W, default 1: width of each input lane and of the output.
- N_IN, default 8: number of lanes. Fixed at 8; any other value is illegal and fails elaboration.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: reset. One clock; reset is asynchronous and active-low.
- i, input, N_IN*DATA_W: packed lanes. Lane k occupies bits [k*DATA_W +: DATA_W].
- s, input, 3: lane select, unsigned, 0..7.
- in_valid, input, 1: qualifies i and s in the current cycle.
- o, output, DATA_W: selected lane, registered.
- out_valid, output, 1: o holds a freshly selected value.

Behaviour:
- Reset: while rst_n is low, o is 0 and out_valid is 0, independent of clk. Assertion takes effect immediately. Release is synchronous to the next rising clk edge.
- On each rising clk edge with rst_n high and in_valid=1:
  - o <= lane s of i.
  - out_valid <= 1.
- On a rising edge with in_valid=0:
  - o holds its previous value.
  - out_valid <= 0.
- Latency: exactly 1 cycle from sampled (i, s, in_valid) to (o, out_valid).
- Throughput: one selection per cycle. There is no backpressure, so in_valid may be high every cycle.
- Select decode is a full case over 0..7: s=0 picks lane 0 (LSB), s=7 picks lane 7 (MSB). No value of s is unused.
- X/Z on s with in_valid=1 is a protocol violation. The RTL drives o to 0 in the default branch so synthesis and simulation match.
- Changes to i or s between clock edges have no effect on o; only the values at the edge matter.
- Reset asserted mid-stream: o and out_valid clear immediately, and any in-flight selection is discarded. The first valid input after release produces out_valid one cycle later.
- No internal state besides the o and out_valid registers.

Decomposition:
- Shared package mux_8to1_pkg:
  - localparam N_IN=8, SEL_W=3.
  - typedef sel_t as logic [SEL_W-1:0].
- One natural sub-module, mux_8to1_core: a purely combinational lane select (i, s -> lane). The top wraps it with the output and valid registers.

Test Plan:
1. Reset: hold rst_n=0 with i=8'hFF, s=3'd5, in_valid=1 and toggle clk -> o=0 and out_valid=0 throughout. Release rst_n, then after one edge -> o=1, out_valid=1.
2. Full select sweep: i=8'b1010_0101, in_valid=1, s stepped 0..7 one per cycle -> o sequence, each 1 cycle after its s, is 1,0,1,0,0,1,0,1.
3. Data change at fixed select: s=3'd3 with i stepped 8'h08, 8'h00, 8'hF7, 8'hFF -> o sequence is 1,0,0,1, each with 1-cycle latency.
4. Valid gating: load o=1 (i=8'h01, s=0, in_valid=1), then set in_valid=0 with i=8'h00 for 3 cycles -> o stays 1 and out_valid=0 for those cycles.
5. Async reset mid-stream: during test 2, pull rst_n low between clock edges -> o and out_valid go to 0 immediately, before the next edge. Stream resumes correctly after release.
6. Wide lanes: DATA_W=4, i=32'h7654_3210, s=6 -> o=4'h6. With s=0 -> o=4'h0, and with s=7 -> o=4'h7.
